dca_matrix_lsu_wdata_formatter: RTL and testbench

Write-direction counterpart of the matrix LSU read-response formatter. It accepts tensor rows from the DCA compute side, narrows each tensor scalar to an LSU element, and masks inactive columns with zero data and zero byte strobes. It emits one AXI W beat per row, with `wlast` generated from the per-transaction burst length. It sits between the tensor-row producer and the AXI write-data channel of the matrix LSU.

---
 rtl/dca_matrix_lsu_wdata_formatter_pkg.sv | 18 +
 rtl/dca_lsu_wbeat_slice.sv | 60 ++++++
 rtl/dca_matrix_lsu_wdata_formatter.sv | 143 ++++++++++++++
 tb/tb_dca_matrix_lsu_wdata_formatter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_lsu_wdata_formatter_pkg.sv
// Shared types and derived widths for the matrix LSU write-data formatter.
package dca_matrix_lsu_wdata_formatter_pkg;

    // Formatter control states (2-bit encoding).
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StDrain = 2'd2
    } wfmt_state_e;

    localparam int unsigned BW_BYTE = 8;

    // Byte strobes covering one LSU element.
    function automatic int unsigned strb_per_element(input int unsigned bw_lsu_element);
        return bw_lsu_element / BW_BYTE;
    endfunction

endpackage

// File: rtl/dca_lsu_wbeat_slice.sv
// One-entry AXI W output register; contents stay frozen while stalled.
module dca_lsu_wbeat_slice #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned STRB_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rstp_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [STRB_WIDTH-1:0] strb_i,
    input  logic                  last_i,
    input  logic                  wready_i,
    output logic                  wvalid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [STRB_WIDTH-1:0] strb_o,
    output logic                  last_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  last_q, last_d;

    // A load always wins; it may replace a beat that is leaving this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            strb_d  = strb_i;
            last_d  = last_i;
        end else if (wready_i) begin
            valid_d = 1'b0;
        end
    end

    // Beat register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rstp_i) begin
        if (rstp_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

    assign wvalid_o = valid_q;
    assign data_o   = data_q;
    assign strb_o   = strb_q;
    assign last_o   = last_q;

endmodule

// File: rtl/dca_matrix_lsu_wdata_formatter.sv
// Turns tensor rows into masked AXI W beats, one beat per row, with wlast
// derived from the latched burst length.
module dca_matrix_lsu_wdata_formatter
    import dca_matrix_lsu_wdata_formatter_pkg::*;
#(
    parameter int unsigned MATRIX_NUM_COL   = 4,
    parameter int unsigned BW_TENSOR_SCALAR = 32,
    parameter int unsigned BW_LSU_ELEMENT   = 32,
    parameter int unsigned BW_AXI_ALEN      = 8
) (
    input  logic                                       clk,
    input  logic                                       rstp,
    input  logic                                       txn_valid,
    output logic                                       txn_ready,
    input  logic [BW_AXI_ALEN-1:0]                     txn_alen,
    input  logic [MATRIX_NUM_COL-1:0]                  txn_col_mask,
    input  logic                                       txn_is_final,
    input  logic                                       tensor_valid,
    output logic                                       tensor_ready,
    input  logic [MATRIX_NUM_COL*BW_TENSOR_SCALAR-1:0] tensor_row,
    output logic                                       wvalid,
    input  logic                                       wready,
    output logic [MATRIX_NUM_COL*BW_LSU_ELEMENT-1:0]   wdata,
    output logic [MATRIX_NUM_COL*BW_LSU_ELEMENT/8-1:0] wstrb,
    output logic                                       wlast,
    output logic                                       inst_done
);

    localparam int unsigned BW_LSU_STRB_PER_ELEMENT = strb_per_element(BW_LSU_ELEMENT);
    localparam int unsigned DATA_W = MATRIX_NUM_COL * BW_LSU_ELEMENT;
    localparam int unsigned STRB_W = MATRIX_NUM_COL * BW_LSU_STRB_PER_ELEMENT;
    localparam logic [BW_AXI_ALEN-1:0] CNT_ONE = 1;

    wfmt_state_e               state_q, state_d;
    logic [BW_AXI_ALEN-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BW_AXI_ALEN-1:0]    alen_q, alen_d;
    logic [MATRIX_NUM_COL-1:0] mask_q, mask_d;
    logic                      final_q, final_d;
    logic                      inst_done_q, inst_done_d;

    logic              beat_load;
    logic [DATA_W-1:0] fmt_data;
    logic [STRB_W-1:0] fmt_strb;
    logic              fmt_last;

    // Column narrowing (plain truncation) and masking of inactive columns.
    always_comb begin
        fmt_data = '0;
        fmt_strb = '0;
        for (int i = 0; i < int'(MATRIX_NUM_COL); i++) begin
            if (mask_q[i]) begin
                fmt_data[i*BW_LSU_ELEMENT +: BW_LSU_ELEMENT] =
                    tensor_row[i*BW_TENSOR_SCALAR +: BW_LSU_ELEMENT];
                fmt_strb[i*BW_LSU_STRB_PER_ELEMENT +: BW_LSU_STRB_PER_ELEMENT] = '1;
            end
        end
    end

    // Compare before increment so alen = all-ones never wraps the counter.
    assign fmt_last = (beat_cnt_q == alen_q);

    // Next-state, handshakes and descriptor latching.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        alen_d       = alen_q;
        mask_d       = mask_q;
        final_d      = final_q;
        inst_done_d  = 1'b0;
        beat_load    = 1'b0;
        txn_ready    = 1'b0;
        tensor_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                txn_ready = 1'b1;
                if (txn_valid) begin
                    alen_d     = txn_alen;
                    mask_d     = txn_col_mask;
                    final_d    = txn_is_final;
                    beat_cnt_d = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                tensor_ready = !wvalid || wready;
                if (tensor_valid && tensor_ready) begin
                    beat_load = 1'b1;
                    if (fmt_last) begin
                        state_d = StDrain;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_ONE;
                    end
                end
            end
            StDrain: begin
                if (wvalid && wready) begin
                    inst_done_d = final_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            alen_q      <= '0;
            mask_q      <= '0;
            final_q     <= 1'b0;
            inst_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            alen_q      <= alen_d;
            mask_q      <= mask_d;
            final_q     <= final_d;
            inst_done_q <= inst_done_d;
        end
    end

    dca_lsu_wbeat_slice #(
        .DATA_WIDTH (DATA_W),
        .STRB_WIDTH (STRB_W)
    ) u_wbeat_slice (
        .clk_i    (clk),
        .rstp_i   (rstp),
        .load_i   (beat_load),
        .data_i   (fmt_data),
        .strb_i   (fmt_strb),
        .last_i   (fmt_last),
        .wready_i (wready),
        .wvalid_o (wvalid),
        .data_o   (wdata),
        .strb_o   (wstrb),
        .last_o   (wlast)
    );

    assign inst_done = inst_done_q;

endmodule

// File: tb/tb_dca_matrix_lsu_wdata_formatter.sv
// Self-checking bench: fixed single-beat table, directed corner sequences and
// random transactions checked against a queue-based beat model.
module tb_dca_matrix_lsu_wdata_formatter;

    localparam int NCOL = 4;
    localparam int BTS  = 32;
    localparam int BLE  = 32;
    localparam int DW   = NCOL * BLE;
    localparam int SW   = DW / 8;

    logic                 clk, rstp;
    logic                 txn_valid, txn_ready, txn_is_final;
    logic [7:0]           txn_alen;
    logic [NCOL-1:0]      txn_col_mask;
    logic                 tensor_valid, tensor_ready;
    logic [NCOL*BTS-1:0]  tensor_row;
    logic                 wvalid, wready, wlast, inst_done;
    logic [DW-1:0]        wdata;
    logic [SW-1:0]        wstrb;

    dca_matrix_lsu_wdata_formatter #(
        .MATRIX_NUM_COL   (NCOL),
        .BW_TENSOR_SCALAR (BTS),
        .BW_LSU_ELEMENT   (BLE),
        .BW_AXI_ALEN      (8)
    ) dut (
        .clk          (clk),
        .rstp         (rstp),
        .txn_valid    (txn_valid),
        .txn_ready    (txn_ready),
        .txn_alen     (txn_alen),
        .txn_col_mask (txn_col_mask),
        .txn_is_final (txn_is_final),
        .tensor_valid (tensor_valid),
        .tensor_ready (tensor_ready),
        .tensor_row   (tensor_row),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .inst_done    (inst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    typedef struct {
        logic [NCOL-1:0]     mask;
        logic [NCOL*BTS-1:0] row;
        bit                  fin;
        logic [DW-1:0]       exp_data;
        logic [SW-1:0]       exp_strb;
    } vec_t;

    // Reference model state.
    beat_t         exp_q[$];
    bit            busy, cur_final, exp_done, stall_prev;
    int            cur_alen, rows_acc, txn_beats;
    logic [3:0]    cur_mask;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_strb;
    logic          prev_last;

    int            n_vec, n_err, cyc, done_cnt;
    int            w_first_cyc, w_last_cyc, txn_acc_cyc;
    logic [DW-1:0] first_wdata;
    logic [SW-1:0] first_wstrb;
    logic          first_wlast;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beat straight from the rules: keep the low element bits of each
    // active column, zero everything for inactive ones.
    function automatic beat_t model_beat(input logic [NCOL*BTS-1:0] row,
                                         input logic [3:0] mask, input bit last);
        beat_t b;
        b.data = '0;
        b.strb = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (mask[c]) begin
                b.data[c*BLE +: BLE] = row[c*BTS +: BLE];
                b.strb[c*(BLE/8) +: (BLE/8)] = '1;
            end
        end
        b.last = last;
        return b;
    endfunction

    // One clock: entered at a negedge with inputs applied, leaves at the next negedge.
    task automatic step();
        bit    exp_wv, exp_tr, w_hs, t_hs, x_hs;
        beat_t b;
        #1;
        exp_wv = exp_q.size() != 0;
        exp_tr = busy && (rows_acc <= cur_alen) && (!exp_wv || wready);
        check("txn_ready", 128'(txn_ready), 128'(!busy));
        check("tensor_ready", 128'(tensor_ready), 128'(exp_tr));
        check("wvalid", 128'(wvalid), 128'(exp_wv));
        check("inst_done", 128'(inst_done), 128'(exp_done));
        if (inst_done) done_cnt++;
        if (exp_wv && wvalid) begin
            check("wdata", 128'(wdata), 128'(exp_q[0].data));
            check("wstrb", 128'(wstrb), 128'(exp_q[0].strb));
            check("wlast", 128'(wlast), 128'(exp_q[0].last));
        end
        if (stall_prev && wvalid) begin
            check("stall_wdata", 128'(wdata), 128'(prev_data));
            check("stall_wstrb", 128'(wstrb), 128'(prev_strb));
            check("stall_wlast", 128'(wlast), 128'(prev_last));
        end
        x_hs = txn_valid && !busy;
        w_hs = exp_wv && wready;
        t_hs = tensor_valid && exp_tr;
        exp_done = 1'b0;
        if (w_hs) begin
            b = exp_q.pop_front();
            if (txn_beats == 0) begin
                w_first_cyc = cyc;
                first_wdata = wdata;
                first_wstrb = wstrb;
                first_wlast = wlast;
            end
            txn_beats++;
            if (b.last) begin
                busy       = 1'b0;
                exp_done   = cur_final;
                w_last_cyc = cyc;
            end
        end
        if (t_hs) begin
            exp_q.push_back(model_beat(tensor_row, cur_mask, rows_acc == cur_alen));
            rows_acc++;
        end
        if (x_hs) begin
            busy        = 1'b1;
            cur_alen    = int'(txn_alen);
            cur_mask    = txn_col_mask;
            cur_final   = txn_is_final;
            rows_acc    = 0;
            txn_beats   = 0;
            txn_acc_cyc = cyc;
        end
        stall_prev = wvalid && !wready;
        prev_data  = wdata;
        prev_strb  = wstrb;
        prev_last  = wlast;
        cyc++;
        @(negedge clk);
    endtask

    // wmode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
    // vmode: 1 rows always valid, 2 random valid plus stray descriptors.
    task automatic run_txn(input int alen, input logic [3:0] mask, input bit fin,
                           input int wmode, input int vmode,
                           input logic [NCOL*BTS-1:0] fixed_row, input bit use_fixed);
        int budget;
        int pat;
        txn_valid    = 1'b1;
        txn_alen     = 8'(alen);
        txn_col_mask = mask;
        txn_is_final = fin;
        tensor_valid = 1'b1;
        tensor_row   = {$urandom, $urandom, $urandom, $urandom};
        wready       = 1'b1;
        budget = 0;
        while (!busy && budget < 20) begin
            step();
            budget++;
        end
        n_vec++;
        if (!busy) begin
            n_err++;
            $display("FAIL txn_accept: got no accept expected accept within 20 cycles");
            txn_valid = 1'b0;
            return;
        end
        pat = 0;
        budget = 0;
        while (busy && budget < 2000) begin
            txn_valid    = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            txn_alen     = 8'($urandom);
            txn_col_mask = 4'($urandom);
            txn_is_final = 1'($urandom);
            tensor_valid = (vmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            tensor_row   = use_fixed ? fixed_row : {$urandom, $urandom, $urandom, $urandom};
            if (wmode == 0) wready = 1'b1;
            else if (wmode == 1) wready = (pat % 4 == 0) || (pat % 4 == 3);
            else wready = 1'($urandom_range(0, 1));
            pat++;
            step();
            budget++;
        end
        n_vec++;
        if (busy) begin
            n_err++;
            $display("FAIL burst_timeout: got unfinished burst expected done within 2000 cycles");
        end
        txn_valid    = 1'b0;
        tensor_valid = 1'b0;
        wready       = 1'b1;
    endtask

    vec_t tbl[5];

    initial begin
        int d0, last1;
        n_vec = 0; n_err = 0; cyc = 0; done_cnt = 0;
        busy = 0; exp_done = 0; stall_prev = 0; rows_acc = 0; cur_alen = 0; txn_beats = 0;
        rstp = 1'b1; txn_valid = 1'b0; txn_alen = '0; txn_col_mask = '0; txn_is_final = 1'b0;
        tensor_valid = 1'b0; tensor_row = '0; wready = 1'b0;

        tbl[0] = '{4'b1111, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1,
                   {32'h4, 32'h3, 32'h2, 32'h1}, 16'hFFFF};
        tbl[1] = '{4'b0101, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0,
                   {32'h0, 32'h3, 32'h0, 32'h1}, 16'h0F0F};
        tbl[2] = '{4'b0000, {32'hA, 32'hB, 32'hC, 32'hD}, 1'b1, 128'h0, 16'h0000};
        tbl[3] = '{4'b1010, {32'hDEADBEEF, 32'h11, 32'hCAFEF00D, 32'h22}, 1'b0,
                   {32'hDEADBEEF, 32'h0, 32'hCAFEF00D, 32'h0}, 16'hF0F0};
        tbl[4] = '{4'b1000, {4{32'hFFFF_FFFF}}, 1'b1,
                   {32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0}, 16'hF000};

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("rst_wvalid", 128'(wvalid), 128'(0));
        check("rst_wlast", 128'(wlast), 128'(0));
        check("rst_inst_done", 128'(inst_done), 128'(0));
        check("rst_wdata", 128'(wdata), 128'(0));
        check("rst_wstrb", 128'(wstrb), 128'(0));
        check("rst_txn_ready", 128'(txn_ready), 128'(1));
        check("rst_tensor_ready", 128'(tensor_ready), 128'(0));
        @(negedge clk);
        rstp = 1'b0;
        wready = 1'b1;
        step();

        // Single-beat table: formatting, masking and inst_done.
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            run_txn(0, tbl[i].mask, tbl[i].fin, 0, 1, tbl[i].row, 1'b1);
            check($sformatf("tbl%0d_wdata", i), 128'(first_wdata), 128'(tbl[i].exp_data));
            check($sformatf("tbl%0d_wstrb", i), 128'(first_wstrb), 128'(tbl[i].exp_strb));
            check($sformatf("tbl%0d_wlast", i), 128'(first_wlast), 128'(1));
            step();
            check($sformatf("tbl%0d_done", i), 128'(done_cnt - d0), 128'(tbl[i].fin));
        end

        // Backpressure: wready 1,0,0,1.
        run_txn(3, 4'hF, 0, 1, 1, '0, 1'b0);
        check("bp_beats", 128'(txn_beats), 128'(4));
        step();

        // Full-rate 256-beat burst.
        run_txn(255, 4'($urandom), 0, 0, 1, '0, 1'b0);
        check("full_beats", 128'(txn_beats), 128'(256));
        check("full_span", 128'(w_last_cyc - w_first_cyc), 128'(255));
        step();

        // Back-to-back descriptors, final only on the second.
        d0 = done_cnt;
        run_txn(2, 4'hF, 0, 0, 1, '0, 1'b0);
        last1 = w_last_cyc;
        run_txn(1, 4'h3, 1, 0, 1, '0, 1'b0);
        check("b2b_bubble", 128'(txn_acc_cyc - last1), 128'(1));
        step();
        check("b2b_done", 128'(done_cnt - d0), 128'(1));

        // Reset at beat 2 of an 8-beat burst.
        txn_valid = 1'b1; txn_alen = 8'd7; txn_col_mask = 4'hF; txn_is_final = 1'b1;
        wready = 1'b1; tensor_valid = 1'b0;
        for (int k = 0; k < 10 && !busy; k++) step();
        txn_valid = 1'b0;
        for (int k = 0; k < 20 && txn_beats < 2; k++) begin
            tensor_valid = 1'b1;
            tensor_row = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("mid_beats_before_rst", 128'(txn_beats), 128'(2));
        rstp = 1'b1;
        #1;
        check("mid_rst_wvalid", 128'(wvalid), 128'(0));
        check("mid_rst_wlast", 128'(wlast), 128'(0));
        check("mid_rst_wdata", 128'(wdata), 128'(0));
        check("mid_rst_txn_ready", 128'(txn_ready), 128'(1));
        check("mid_rst_tensor_ready", 128'(tensor_ready), 128'(0));
        busy = 0; exp_q.delete(); exp_done = 0; stall_prev = 0;
        @(negedge clk);
        rstp = 1'b0;
        tensor_valid = 1'b0;
        step();
        d0 = done_cnt;
        run_txn(0, 4'hF, 1, 0, 1, '0, 1'b0);
        check("post_rst_beats", 128'(txn_beats), 128'(1));
        step();
        check("post_rst_done", 128'(done_cnt - d0), 128'(1));

        // Random transactions with random handshakes and stray inputs.
        for (int t = 0; t < 25; t++) begin
            run_txn($urandom_range(0, 12), 4'($urandom), 1'($urandom), 2, 2, '0, 1'b0);
        end
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
